// File: rtl/fg_pkg.sv
// Shared state encoding and 50 MHz timing defaults for the function generator DAC path.
package fg_pkg;

    localparam logic [2:0] ST_CLEAR  = 3'd0;
    localparam logic [2:0] ST_PWRDN  = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_SETUP  = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_HOLD   = 3'd5;
    localparam logic [2:0] ST_SETTLE = 3'd6;

    localparam int FG_WR_CYCLES_50MHZ     = 2;
    localparam int FG_SETTLE_CYCLES_50MHZ = 500;

    // Cycles spent in SETTLE proper: the settle interval runs from wr_n rising to
    // the next SETUP entry, so HOLD and the one IDLE/strobe cycle are part of it.
    function automatic int settle_len(int settle, int hold);
        return settle - 1 - hold;
    endfunction

endpackage

// File: rtl/fg_phase_timer.sv
// Loadable down-counter shared by every sequencer phase; holds at zero.
module fg_phase_timer #(
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/fg_dac_sequencer.sv
// Parallel DAC write sequencer: latches samples, times the wr_n pulse and settle gap,
// and owns clear-after-reset and power-down while disabled.
//
// state  | meaning
// CLEAR  | dac_clr_n low after reset
// PWRDN  | disabled, dac_pd_n low
// IDLE   | ready for a sample
// SETUP  | data on bus, wr_n high
// WRITE  | wr_n low
// HOLD   | wr_n high, data held
// SETTLE | waiting out the DAC settling interval
module fg_dac_sequencer
    import fg_pkg::*;
#(
    parameter int BITWIDTH      = 8,
    parameter int SETUP_CYCLES  = 1,
    parameter int WR_CYCLES     = FG_WR_CYCLES_50MHZ,
    parameter int HOLD_CYCLES   = 1,
    parameter int SETTLE_CYCLES = FG_SETTLE_CYCLES_50MHZ,
    parameter int CLR_CYCLES    = 4,
    parameter int CNT_WIDTH     = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [BITWIDTH-1:0] sample_i,
    input  logic                sampleValid_i,
    output logic                sampleReady_o,
    output logic [BITWIDTH-1:0] dac_data_o,
    output logic                dac_wr_n_o,
    output logic                dac_clr_n_o,
    output logic                dac_pd_n_o,
    output logic                busy_o,
    output logic                overrun_o
);

    localparam int SETTLE_LEN = settle_len(SETTLE_CYCLES, HOLD_CYCLES);

    localparam logic [CNT_WIDTH-1:0] SETUP_LD  = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WR_LD     = CNT_WIDTH'(WR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LD   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LD = CNT_WIDTH'((SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0);
    // Reset leaves the counter at zero, so the first CLEAR cycle loads the remainder.
    localparam logic [CNT_WIDTH-1:0] CLR_LD    = CNT_WIDTH'((CLR_CYCLES > 1) ? CLR_CYCLES - 2 : 0);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 clr_armed;
    logic                 timer_load;
    logic [CNT_WIDTH-1:0] timer_val;
    logic                 timer_zero;
    logic                 accept;
    logic [2:0]           rest_state;

    fg_phase_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    assign rest_state = enable_i ? ST_IDLE : ST_PWRDN;

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_val  = '0;
        accept     = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (!clr_armed) begin
                    if (CLR_CYCLES == 1) begin
                        state_nxt = rest_state;
                    end else begin
                        timer_load = 1'b1;
                        timer_val  = CLR_LD;
                    end
                end else if (timer_zero) begin
                    state_nxt = rest_state;
                end
            end
            ST_PWRDN: begin
                if (enable_i) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (!enable_i) begin
                    state_nxt = ST_PWRDN;
                end else if (sampleValid_i) begin
                    state_nxt  = ST_SETUP;
                    timer_load = 1'b1;
                    timer_val  = SETUP_LD;
                    accept     = 1'b1;
                end
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    state_nxt  = ST_WRITE;
                    timer_load = 1'b1;
                    timer_val  = WR_LD;
                end
            end
            ST_WRITE: begin
                if (timer_zero) begin
                    state_nxt  = ST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    if (SETTLE_LEN > 0) begin
                        state_nxt  = ST_SETTLE;
                        timer_load = 1'b1;
                        timer_val  = SETTLE_LD;
                    end else begin
                        state_nxt = rest_state;
                    end
                end
            end
            ST_SETTLE: begin
                if (timer_zero) state_nxt = rest_state;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_CLEAR;
            clr_armed     <= 1'b0;
            dac_data_o    <= '0;
            dac_wr_n_o    <= 1'b1;
            dac_clr_n_o   <= 1'b0;
            dac_pd_n_o    <= 1'b1;
            sampleReady_o <= 1'b0;
            busy_o        <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            state         <= state_nxt;
            if (state == ST_CLEAR) clr_armed <= 1'b1;
            if (accept) dac_data_o <= sample_i;
            dac_wr_n_o    <= (state_nxt != ST_WRITE);
            dac_clr_n_o   <= (state_nxt != ST_CLEAR);
            dac_pd_n_o    <= (state_nxt != ST_PWRDN);
            sampleReady_o <= (state_nxt == ST_IDLE);
            busy_o        <= (state_nxt inside {ST_SETUP, ST_WRITE, ST_HOLD, ST_SETTLE});
            if (state_nxt == ST_PWRDN) begin
                overrun_o <= 1'b0;
            end else if (sampleValid_i && enable_i && (state != ST_IDLE)) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fg_dac_sequencer.sv
// Bench for fg_dac_sequencer: directed table, multi-cycle sequences, and random
// stimulus checked every cycle against a timestamp-based reference model.
module tb_fg_dac_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] sample = 8'h00;

    logic       ready_a, wr_a, clr_a, pd_a, busy_a, ovr_a;
    logic [7:0] data_a;
    logic       ready_b, wr_b, clr_b, pd_b, busy_b, ovr_b;
    logic [7:0] data_b;

    always #5 clk = ~clk;

    fg_dac_sequencer dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .sample_i(sample), .sampleValid_i(valid),
        .sampleReady_o(ready_a), .dac_data_o(data_a), .dac_wr_n_o(wr_a), .dac_clr_n_o(clr_a),
        .dac_pd_n_o(pd_a), .busy_o(busy_a), .overrun_o(ovr_a)
    );

    fg_dac_sequencer #(.SETUP_CYCLES(2), .WR_CYCLES(3), .HOLD_CYCLES(2), .SETTLE_CYCLES(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .sample_i(sample), .sampleValid_i(valid),
        .sampleReady_o(ready_b), .dac_data_o(data_b), .dac_wr_n_o(wr_b), .dac_clr_n_o(clr_b),
        .dac_pd_n_o(pd_b), .busy_o(busy_b), .overrun_o(ovr_b)
    );

    typedef struct {int setup; int wr; int hold; int settle; int clr;} prm_t;
    typedef struct {
        bit known; bit clearing; int clr_cnt; bit powered;
        int avail; int acc_t; logic [7:0] data; bit ovr;
    } mdl_t;
    typedef struct {logic r; logic e; logic v; logic [7:0] s; logic [7:0] data; logic [5:0] flags;} vec_t;

    prm_t pa, pb;
    mdl_t ma, mb;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Outputs follow from timestamps: when the last sample was taken and when the
    // sequencer is next free (SETTLE cycles after wr_n rises, or after HOLD if longer).
    function automatic logic [13:0] predict(mdl_t m, prm_t p, int c);
        logic busy, wr_n, ready, pd_n;
        busy  = !m.clearing && (c < m.avail);
        wr_n  = !((c >= m.acc_t + 1 + p.setup) && (c <= m.acc_t + p.setup + p.wr));
        ready = !m.clearing && !busy && m.powered;
        pd_n  = m.clearing || busy || m.powered;
        return {m.data, wr_n, !m.clearing, pd_n, ready, busy, m.ovr};
    endfunction

    function automatic mdl_t step(mdl_t m, prm_t p, int c, logic r, logic e, logic v, logic [7:0] s);
        mdl_t n;
        n = m;
        if (r) begin
            n.known = 1; n.clearing = 1; n.clr_cnt = 0; n.powered = 0;
            n.avail = 0; n.acc_t = -1000000; n.data = 8'h00; n.ovr = 0;
            return n;
        end
        if (!m.known) return n;
        if (m.clearing) begin
            n.clr_cnt = m.clr_cnt + 1;
            if (v && e) n.ovr = 1;
            if (n.clr_cnt == p.clr) begin
                n.clearing = 0; n.powered = e;
                if (!e) n.ovr = 0;
            end
        end else if (c < m.avail) begin
            if (v && e) n.ovr = 1;
            if (c == m.avail - 1) begin
                n.powered = e;
                if (!e) n.ovr = 0;
            end
        end else if (m.powered) begin
            if (!e) begin
                n.powered = 0; n.ovr = 0;
            end else if (v) begin
                n.acc_t = c; n.data = s;
                n.avail = c + 1 + p.setup + p.wr + ((p.settle - 1 > p.hold) ? p.settle - 1 : p.hold);
            end
        end else begin
            if (e) begin
                n.powered = 1;
                if (v) n.ovr = 1;
            end else begin
                n.ovr = 0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        cyc++;
        if (ma.known) chk("model_a", {18'd0, data_a, wr_a, clr_a, pd_a, ready_a, busy_a, ovr_a}, {18'd0, predict(ma, pa, cyc)});
        if (mb.known) chk("model_b", {18'd0, data_b, wr_b, clr_b, pd_b, ready_b, busy_b, ovr_b}, {18'd0, predict(mb, pb, cyc)});
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic [7:0] s);
        rst = r; en = e; valid = v; sample = s;
        ma = step(ma, pa, cyc, r, e, v, s);
        mb = step(mb, pb, cyc, r, e, v, s);
    endtask

    vec_t tv[9];
    int   rise, rdy_at, wr_lows, low, n, pre_ovr;
    logic prev_wr_b;
    int   falls[$];

    initial begin
        pa = '{1, 2, 1, 500, 4};
        pb = '{2, 3, 2, 5, 4};
        ma = '{default: 0};
        mb = '{default: 0};

        // {rst, en, valid, sample, expected data, expected {clr_n, ready, wr_n, pd_n, busy, ovr}}
        tv[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 6'b001100};
        tv[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 6'b001100};
        tv[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 6'b001100};
        tv[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 6'b001100};
        tv[4] = '{1'b0, 1'b1, 1'b1, 8'hA5, 8'h00, 6'b111100};
        tv[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 6'b101110};
        tv[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 6'b100110};
        tv[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 6'b100110};
        tv[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 6'b101110};

        sync(); drive(1, 1, 0, 8'h00);
        sync(); drive(1, 1, 0, 8'h00);

        for (int i = 0; i < 9; i++) begin
            sync();
            drive(tv[i].r, tv[i].e, tv[i].v, tv[i].s);
            chk("vec_flags", {26'd0, clr_a, ready_a, wr_a, pd_a, busy_a, ovr_a}, {26'd0, tv[i].flags});
            chk("vec_data", {24'd0, data_a}, {24'd0, tv[i].data});
        end

        // Settle after the first write, with a strobe 100 cycles into it.
        rise = cyc; rdy_at = -1; wr_lows = 0;
        for (int k = 1; k <= 700; k++) begin
            sync();
            if (k == 101) begin
                chk("overrun_set", {31'd0, ovr_a}, 32'd1);
                chk("data_held", {24'd0, data_a}, 32'hA5);
            end
            if (ready_a) begin
                rdy_at = cyc;
                break;
            end
            if (!wr_a) wr_lows++;
            if (k == 100) drive(0, 1, 1, 8'h3C);
            else drive(0, 1, 0, 8'h00);
        end
        chk("settle_to_ready", rdy_at - rise, pa.settle - 1);
        chk("no_extra_wr", wr_lows, 0);

        // Disable mid-write: pulse completes, then power-down clears overrun.
        drive(0, 1, 1, 8'h5A);
        for (int k = 0; k < 10; k++) begin
            sync();
            if (!wr_a) break;
            drive(0, 1, 0, 8'h00);
        end
        drive(0, 0, 0, 8'h00);
        low = 1;
        for (int k = 0; k < 10; k++) begin
            sync();
            if (wr_a) break;
            low++;
            drive(0, 0, 0, 8'h00);
        end
        chk("wr_low_width", low, pa.wr);
        drive(0, 0, 0, 8'h00);
        pre_ovr = 0;
        for (int k = 0; k < 700; k++) begin
            sync();
            if (!pd_a) break;
            pre_ovr = ovr_a;
            drive(0, 0, 0, 8'h00);
        end
        chk("ovr_before_pd", pre_ovr, 1);
        chk("pd_asserted", {31'd0, pd_a}, 32'd0);
        chk("ovr_cleared_in_pd", {31'd0, ovr_a}, 32'd0);
        chk("data_kept_in_pd", {24'd0, data_a}, 32'h5A);
        chk("ready_in_pd", {31'd0, ready_a}, 32'd0);
        drive(0, 0, 0, 8'h00);
        sync(); drive(0, 1, 0, 8'h00);
        sync();
        chk("ready_after_enable", {31'd0, ready_a}, 32'd1);
        chk("pd_released", {31'd0, pd_a}, 32'd1);

        // Reset during WRITE aborts the pulse and restarts the clear sequence.
        drive(0, 1, 1, 8'h77);
        for (int k = 0; k < 10; k++) begin
            sync();
            if (!wr_a) break;
            drive(0, 1, 0, 8'h00);
        end
        drive(1, 1, 0, 8'h00);
        sync();
        chk("rst_wr_n", {31'd0, wr_a}, 32'd1);
        chk("rst_clr_n", {31'd0, clr_a}, 32'd0);
        chk("rst_data", {24'd0, data_a}, 32'd0);
        drive(0, 1, 0, 8'h00);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            sync();
            if (clr_a) break;
            n++;
            drive(0, 1, 0, 8'h00);
        end
        chk("clear_width", n, pa.clr);
        chk("ready_after_clear", {31'd0, ready_a}, 32'd1);

        // Short-timing instance, strobing at every ready cycle.
        prev_wr_b = wr_b;
        for (int k = 0; k < 70; k++) begin
            drive(0, 1, ready_b, 8'($urandom));
            sync();
            if (prev_wr_b && !wr_b) falls.push_back(cyc);
            prev_wr_b = wr_b;
        end
        chk("b2b_no_overrun", {31'd0, ovr_b}, 32'd0);
        chk("b2b_falls_seen", (falls.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 1; i < falls.size(); i++)
            chk("b2b_wr_period", falls[i] - falls[i-1], pb.setup + pb.wr + pb.settle);

        // Random traffic against the reference model.
        for (int k = 0; k < 4000; k++) begin
            drive(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  8'($urandom));
            sync();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
